overflow_channel_scheduler: RTL
===============================

Name: overflow_channel_scheduler

Overview:
- Time-shares one overflow_protection (saturation/wrap) stage between NUM_CH accumulator channels of the multi-channel FIR.
- Round-robin arbitrates channel requests and drives the shared stage with the granted sample and that channel's overflow mode.
- Tags results back to the source channel.
- Tracks per-channel consecutive overflows; on escalation, forces the channel into saturate mode until cleared.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16)
- INPUT_WIDTH, 24, accumulator sample width
- OUTPUT_WIDTH, 16, protected output width
- OVF_LIMIT, 8, consecutive overflowed results that trip ch_fault (1..255)
- CH_W (localparam), $clog2(NUM_CH), channel tag width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  when low, no new grants; in-flight samples complete
- req_data  in  NUM_CH*INPUT_WIDTH  channel i sample at [i*INPUT_WIDTH +: INPUT_WIDTH]
- req_valid  in  NUM_CH  per-channel sample valid
- req_ready  out  NUM_CH  one-hot grant; transfer when req_valid[i] & req_ready[i]
- ch_mode  in  2*NUM_CH  per-channel configured mode, channel i at [2i +: 2]
- fault_clr  in  NUM_CH  per-channel clear of ch_fault and counter
- prot_data_in  out  INPUT_WIDTH  sample to shared stage
- prot_data_valid  out  1  sample valid to shared stage
- prot_overflow_mode  out  2  effective mode for that sample
- prot_data_out  in  OUTPUT_WIDTH  shared-stage result
- prot_data_ready  in  1  shared-stage result valid
- prot_overflow_flag  in  1  shared-stage overflow flag
- res_data  out  OUTPUT_WIDTH  tagged result
- res_valid  out  1  result valid, single-cycle pulse
- res_ch  out  CH_W  channel of res_data
- res_overflow  out  1  overflow flag of the result
- ch_fault  out  NUM_CH  sticky escalation flag per channel
- busy  out  1  any sample in flight (issue or wait stage)
- proto_err  out  1  sticky: expected prot_data_ready missing

Behaviour:
- Reset (asynchronous, immediate): all outputs 0; RR pointer = NUM_CH-1, so channel 0 has first priority; counters, tags and in-flight samples discarded.
- Arbitration (cycle T, combinational):
  - If enable, grant the first valid channel in order pointer+1, pointer+2, … (modulo NUM_CH).
  - req_ready is one-hot or zero; at most one transfer per cycle.
  - Pointer updates to the granted channel only on transfer; otherwise it holds.
- Issue (T+1, registered):
  - prot_data_valid=1, prot_data_in = sample.
  - prot_overflow_mode = 2'b00 if ch_fault[ch] else ch_mode[ch]; mode is sampled at T.
  - Tag {valid, ch} enters the stage-1 tag register, then stage 2 at T+2.
- Shared stage latency is fixed at 1 cycle: prot_data_ready is expected at T+2.
- Result (T+3, registered):
  - res_valid=1, res_data=prot_data_out, res_overflow=prot_overflow_flag, res_ch = stage-2 tag.
  - Handshake-to-result latency is 3 cycles; full throughput is 1 sample/cycle.
- Protocol checks:
  - Stage-2 tag valid with prot_data_ready=0 sets proto_err; no result is emitted for that sample.
  - prot_data_ready=1 with no stage-2 tag is ignored and also sets proto_err.
- Escalation, evaluated on each result for channel c:
  - res_overflow=1: cnt[c] increments, saturating at OVF_LIMIT.
  - res_overflow=0: cnt[c] is cleared.
  - cnt[c] reaching OVF_LIMIT sets ch_fault[c] in the same cycle res_valid is emitted.
- fault_clr[c] clears ch_fault[c] and cnt[c] next cycle. It wins over a simultaneous increment or set.
- Samples already issued keep the mode captured at grant; a fault affects only later grants.
- busy = stage-1 or stage-2 tag valid.
- enable deasserted: in-flight results still emerge; req_ready all 0.

Decomposition:
- Package ovf_sched_pkg:
  - mode constants MODE_SAT=2'b00, MODE_WRAP=2'b01, MODE_FLAG=2'b10, MODE_BYPASS=2'b11
  - PROT_LATENCY=1
  - tag struct {valid, ch}
- Sub-module rr_arbiter (parameter N): req vector and advance strobe in; one-hot grant and index out; owns the pointer.

Test Plan:
- All 4 channels valid continuously, enable=1 → grants 0,1,2,3,0,… one per cycle; res_ch follows 3 cycles later; res_valid high every cycle.
- ch1 sends 24'h010000 in mode 00 with a behavioural protection model → res_data=16'h7FFF, res_overflow=1, res_ch=1; 8 consecutive such samples set ch_fault[1] with the 8th res_valid.
- ch1 faulted, ch_mode[1]=2'b01 → prot_overflow_mode=2'b00 for ch1 grants; pulse fault_clr[1] → next ch1 grant issues mode 01.
- Overflow sequence 7× overflow, 1× clean (24'h000100), 7× overflow on ch2 → ch_fault[2] stays 0.
- Protection model drops one prot_data_ready → proto_err=1, that result missing, following results correct.
- rst asserted mid-stream with 2 samples in flight → outputs 0 immediately, no stale res_valid after release; first grant goes to channel 0.

Source files
------------

// File: rtl/ovf_sched_pkg.sv
// Shared types and constants for the overflow channel scheduler.
// Tags carry up to 16 channels; unused upper tag bits stay zero.
package ovf_sched_pkg;

    localparam logic [1:0] MODE_SAT    = 2'b00;
    localparam logic [1:0] MODE_WRAP   = 2'b01;
    localparam logic [1:0] MODE_FLAG   = 2'b10;
    localparam logic [1:0] MODE_BYPASS = 2'b11;

    localparam int PROT_LATENCY = 1;
    localparam int TAG_CH_W     = 4;
    localparam int CNT_W        = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_CH_W-1:0] ch;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// The pointer moves only when the caller strobes advance.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    logic [W-1:0] ptr;
    logic         found;
    int           c;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 1; i <= N; i++) begin
            c = (int'(ptr) + i) % N;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = W'(c);
            end
        end
    end

    // Reset to N-1 so channel 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= W'(N - 1);
        end else if (advance) begin
            ptr <= idx;
        end
    end

endmodule

// File: rtl/overflow_channel_scheduler.sv
// Time-shares one overflow protection stage across NUM_CH channels,
// tags results back to their source and escalates persistent overflow.
module overflow_channel_scheduler
    import ovf_sched_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int INPUT_WIDTH  = 24,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OVF_LIMIT    = 8,
    localparam int CH_W        = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [NUM_CH*INPUT_WIDTH-1:0] req_data,
    input  logic [NUM_CH-1:0]             req_valid,
    output logic [NUM_CH-1:0]             req_ready,
    input  logic [2*NUM_CH-1:0]           ch_mode,
    input  logic [NUM_CH-1:0]             fault_clr,
    output logic [INPUT_WIDTH-1:0]        prot_data_in,
    output logic                          prot_data_valid,
    output logic [1:0]                    prot_overflow_mode,
    input  logic [OUTPUT_WIDTH-1:0]       prot_data_out,
    input  logic                          prot_data_ready,
    input  logic                          prot_overflow_flag,
    output logic [OUTPUT_WIDTH-1:0]       res_data,
    output logic                          res_valid,
    output logic [CH_W-1:0]               res_ch,
    output logic                          res_overflow,
    output logic [NUM_CH-1:0]             ch_fault,
    output logic                          busy,
    output logic                          proto_err
);

    logic [NUM_CH-1:0] arb_req;
    logic [NUM_CH-1:0] grant;
    logic [CH_W-1:0]   gidx;
    logic              xfer;
    tag_t              tag1;
    tag_t              tag2;
    logic              emit;
    logic [CH_W-1:0]   rc;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic              unused_tag_hi;

    // Gating with rst keeps req_ready low for the whole reset window.
    assign arb_req   = req_valid & {NUM_CH{enable & ~rst}};
    assign req_ready = grant;
    assign xfer      = |grant;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant),
        .idx     (gidx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prot_data_valid    <= 1'b0;
            prot_data_in       <= '0;
            prot_overflow_mode <= MODE_SAT;
            tag1               <= '0;
            tag2               <= '0;
        end else begin
            prot_data_valid <= xfer;
            tag1.valid      <= xfer;
            tag2            <= tag1;
            if (xfer) begin
                prot_data_in <= req_data[int'(gidx)*INPUT_WIDTH +: INPUT_WIDTH];
                prot_overflow_mode <= ch_fault[gidx] ? MODE_SAT
                                    : ch_mode[2*int'(gidx) +: 2];
                tag1.ch <= TAG_CH_W'(gidx);
            end
        end
    end

    assign emit          = tag2.valid & prot_data_ready;
    assign rc            = tag2.ch[CH_W-1:0];
    assign busy          = tag1.valid | tag2.valid;
    assign unused_tag_hi = ^tag2.ch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_ch       <= '0;
            res_overflow <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            res_valid <= emit;
            proto_err <= proto_err | (tag2.valid != prot_data_ready);
            if (emit) begin
                res_data     <= prot_data_out;
                res_ch       <= rc;
                res_overflow <= prot_overflow_flag;
            end
        end
    end

    // Clears are applied last so they override a same-cycle trip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_fault <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else begin
            if (emit) begin
                if (prot_overflow_flag) begin
                    if (cnt[rc] != CNT_W'(OVF_LIMIT))
                        cnt[rc] <= cnt[rc] + CNT_W'(1);
                    if (cnt[rc] >= CNT_W'(OVF_LIMIT - 1))
                        ch_fault[rc] <= 1'b1;
                end else begin
                    cnt[rc] <= '0;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (fault_clr[i]) begin
                    cnt[i]      <= '0;
                    ch_fault[i] <= 1'b0;
                end
            end
        end
    end

endmodule
